// File: rtl/ce_nco_pkg.sv
// ce_nco_pkg: shared settle FSM states and width helper for the NCO clock-enable bank.
package ce_nco_pkg;
    typedef enum logic [1:0] {ST_RESET, ST_SETTLE, ST_LOCKED} st_t;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ce_nco_chan.sv
// ce_nco_chan: one NCO accumulator with load mux and registered carry-out enable.
// CE_NCO_MODE_EN adds a second increment bank selected by the registered mode.
module ce_nco_chan #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
`ifdef CE_NCO_MODE_EN
    input  logic             ld_bank,
    input  logic             mode_q,
`endif
    input  logic [ACC_W-1:0] ld_inc,
    input  logic [ACC_W-1:0] ld_phase,
    output logic             ce
);
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_inc;
    logic [ACC_W:0]   w_sum;
    logic             r_ce;
`ifdef CE_NCO_MODE_EN
    logic [ACC_W-1:0] r_bank [2];
    assign w_inc = r_bank[mode_q];
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank[0] <= '0;
            r_bank[1] <= '0;
        end else if (ld) begin
            r_bank[ld_bank] <= ld_inc;
        end
    end
`else
    logic [ACC_W-1:0] r_inc;
    assign w_inc = r_inc;
    always_ff @(posedge clk) begin
        if (rst) r_inc <= '0;
        else if (ld) r_inc <= ld_inc;
    end
`endif
    // The carry out of the modulo add is the pulse event.
    assign w_sum = {1'b0, r_acc} + {1'b0, w_inc};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_ce  <= 1'b0;
        end else if (ld) begin
            r_acc <= ld_phase;
            r_ce  <= 1'b0;
        end else begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ce  <= w_sum[ACC_W];
        end
    end
    assign ce = r_ce;
endmodule

// File: rtl/ce_nco_bank.sv
// ce_nco_bank: NUM_CH NCO clock-enable generators with config handshake and settle/lock FSM.
// Optional CE_NCO_MODE_EN: dual increment banks switched by a registered mode input.
module ce_nco_bank
    import ce_nco_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int ACC_W  = 32,
    parameter int SETTLE = 16,
    localparam int CH_W  = ch_w(NUM_CH)
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
`ifdef CE_NCO_MODE_EN
    input  logic              mode,
    input  logic              cfg_bank,
`endif
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);
    localparam int CNT_W = ch_w(SETTLE);
    localparam logic [CNT_W-1:0] CNT_RLD = CNT_W'(SETTLE - 1);
    st_t              r_st, w_st_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_ready;
    logic             w_ld_ok;
    logic             w_mode_chg;
    logic             w_evt;
    assign w_ld_ok = cfg_valid && r_ready && ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
`ifdef CE_NCO_MODE_EN
    logic r_mode_q;
    assign w_mode_chg = mode != r_mode_q;
    always_ff @(posedge refclk) begin
        if (rst) r_mode_q <= 1'b0;
        else r_mode_q <= mode;
    end
`else
    assign w_mode_chg = 1'b0;
`endif
    assign w_evt = w_ld_ok || w_mode_chg;
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_st    <= ST_RESET;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_st    <= w_st_nx;
            r_cnt   <= w_cnt_nx;
            r_ready <= 1'b1;
        end
    end
    always_comb begin
        w_st_nx  = r_st;
        w_cnt_nx = r_cnt;
        case (r_st)
            ST_RESET: begin
                w_st_nx  = ST_SETTLE;
                w_cnt_nx = CNT_RLD;
            end
            ST_SETTLE: begin
                w_st_nx  = (!w_evt && r_cnt == '0) ? ST_LOCKED : ST_SETTLE;
                w_cnt_nx = w_evt ? CNT_RLD : (r_cnt == '0 ? r_cnt : r_cnt - 1'b1);
            end
            ST_LOCKED: begin
                w_st_nx  = w_evt ? ST_SETTLE : ST_LOCKED;
                w_cnt_nx = CNT_RLD;
            end
            default: begin
                w_st_nx  = ST_RESET;
                w_cnt_nx = '0;
            end
        endcase
    end
    assign cfg_ready = r_ready;
    assign locked    = r_st == ST_LOCKED;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ce_nco_chan #(.ACC_W(ACC_W)) u_chan (
            .clk      (refclk),
            .rst      (rst),
            .ld       (w_ld_ok && cfg_ch == CH_W'(i)),
`ifdef CE_NCO_MODE_EN
            .ld_bank  (cfg_bank),
            .mode_q   (r_mode_q),
`endif
            .ld_inc   (cfg_inc),
            .ld_phase (cfg_phase),
            .ce       (ce[i])
        );
    end
endmodule

// File: tb/tb_ce_nco_bank.sv
// tb_ce_nco_bank: scoreboard bench with an arithmetic reference model of the NCO bank.
module tb_ce_nco_bank;
    localparam int NUM_CH = 3;
    localparam int ACC_W  = 8;
    localparam int SETTLE = 4;
    localparam int MOD    = 1 << ACC_W;

    typedef struct {
        logic [NUM_CH-1:0] ce;
        logic              locked;
        logic              ready;
    } exp_t;

    logic              refclk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [1:0]        cfg_ch = '0;
    logic [ACC_W-1:0]  cfg_inc = '0;
    logic [ACC_W-1:0]  cfg_phase = '0;
    logic              mode = 1'b0;
    logic              cfg_bank = 1'b0;
    logic [NUM_CH-1:0] ce;
    logic              locked;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    ce_nco_bank #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .SETTLE(SETTLE)) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
`ifdef CE_NCO_MODE_EN
        .mode      (mode),
        .cfg_bank  (cfg_bank),
`endif
        .ce        (ce),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    // Reference model: channel rates from plain modulo arithmetic, lock from
    // the number of edges elapsed since the most recent settle event.
    int m_acc [NUM_CH];
    int m_bank [NUM_CH][2];
    int m_mq, m_ready, m_last, m_n;
    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            m_acc[c] = 0;
            m_bank[c][0] = 0;
            m_bank[c][1] = 0;
        end
        m_mq = 0; m_ready = 0; m_last = 0; m_n = 0;
    end

    always @(posedge refclk) begin : mdl
        exp_t e;
        int   s, bk, md, ldv, inc;
        e.ce = '0;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_acc[c] = 0;
                m_bank[c][0] = 0;
                m_bank[c][1] = 0;
            end
            m_mq = 0;
            m_ready = 0;
            m_last = m_n + 1;
        end else begin
            bk = 0;
            md = 0;
`ifdef CE_NCO_MODE_EN
            bk = int'(cfg_bank);
            md = int'(mode);
`endif
            ldv = (cfg_valid && m_ready != 0 && int'(cfg_ch) < NUM_CH) ? 1 : 0;
            for (int c = 0; c < NUM_CH; c++) begin
                inc = m_bank[c][m_mq];
                if (ldv != 0 && int'(cfg_ch) == c) begin
                    m_bank[c][bk] = int'(cfg_inc);
                    m_acc[c] = int'(cfg_phase);
                end else begin
                    s = m_acc[c] + inc;
                    e.ce[c] = s >= MOD;
                    m_acc[c] = s % MOD;
                end
            end
            if (md != m_mq) begin
                m_mq = md;
                m_last = m_n;
            end
            if (ldv != 0) m_last = m_n;
            m_ready = 1;
        end
        e.locked = (m_n - m_last) >= SETTLE;
        e.ready = m_ready != 0;
        m_n++;
        q.push_back(e);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge refclk) begin : mon
        exp_t e;
        #1;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty @%0t: got 0 entries expected 1", $time);
        end else begin
            e = q.pop_front();
            chk("ce", (^ce === 1'bx) ? -1 : int'(ce), int'(e.ce));
            chk("locked", (locked === 1'bx) ? -1 : int'(locked), int'(e.locked));
            chk("cfg_ready", (cfg_ready === 1'bx) ? -1 : int'(cfg_ready), int'(e.ready));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic load(input int ch, input int inc, input int ph, input int bk);
        cfg_valid = 1'b1;
        cfg_ch    = ch[1:0];
        cfg_inc   = inc[ACC_W-1:0];
        cfg_phase = ph[ACC_W-1:0];
        cfg_bank  = bk[0];
        @(negedge refclk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(8);
        load(0, 64, 0, 0);
        wait_cyc(14);
        load(1, 96, 0, 0);
        wait_cyc(18);
        load(2, 64, 192, 0);
        wait_cyc(12);
        load(3, 200, 17, 0);
        wait_cyc(8);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(6);
`ifdef CE_NCO_MODE_EN
        load(0, 64, 0, 0);
        load(0, 128, 0, 1);
        wait_cyc(12);
        mode = 1'b1;
        wait_cyc(12);
        mode = 1'b0;
        wait_cyc(8);
`endif
        load(1, 255, 255, 0);
        load(2, 0, 128, 0);
        wait_cyc(8);
        for (int i = 0; i < 3000; i++) begin
            cfg_valid = ($urandom % 6) == 0;
            cfg_ch    = 2'($urandom % 4);
            cfg_inc   = (($urandom % 8) == 0) ? '0 : ACC_W'($urandom);
            cfg_phase = ACC_W'($urandom);
            cfg_bank  = 1'($urandom);
            if (($urandom % 40) == 0) mode = ~mode;
            rst = ($urandom % 300) == 0;
            @(negedge refclk);
        end
        cfg_valid = 1'b0;
        rst = 1'b0;
        wait_cyc(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
